mc_datapath: RTL and testbench
==============================

Name: mc_datapath

Overview:
- 32-bit multicycle RV32I datapath. It sits directly downstream of the multicycle controller FSM and consumes its registered control signals each cycle.
- Feeds op/funct3/funct7/zero back to the controller.
- Drives the shared instruction/data memory address and write data.
- Holds PC, OldPC, IR, the nonarchitectural A/B/ALUOut/Data registers, and the 32x32 register file.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- PCWrite_i  in  1  load PC from Result
- AdrSrc_i  in  1  memory address select: 0=PC, 1=Result
- IRWrite_i  in  1  load Instr and OldPC
- RegWrite_i  in  1  register file write enable
- ALUSrcA_i  in  2  00=PC, 01=OldPC, 10=A, 11=32'b0
- ALUSrcB_i  in  2  00=B, 01=ImmExt, 10=32'd4, 11=32'b0
- ResultSrc_i  in  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
- ALUControl_i  in  3  000 add, 001 sub, 010 and, 011 or, 101 slt; others give 0
- ImmSrc_i  in  3  000 I, 001 S, 010 B, 011 J, 100 U; others give I
- ReadData_i  in  32  memory read data
- Adr_o  out  32  memory address
- WriteData_o  out  32  memory write data (= B register)
- op_o  out  7  Instr[6:0]
- funct3_o  out  3  Instr[14:12]
- funct7_o  out  1  Instr[30]
- zero_o  out  1  ALUResult == 0

Behaviour:
- Reset has priority over every enable.
  - PC <= RESET_PC.
  - OldPC, Instr, A, B, ALUOut and Data all clear to 0.
  - Register file contents are not cleared.
  - Outputs after reset: op_o=0, funct3_o=0, funct7_o=0, WriteData_o=0, Adr_o=RESET_PC when AdrSrc_i=0.
- PC updates on a clock edge only when PCWrite_i=1: PC <= Result. Otherwise PC holds.
- When IRWrite_i=1, on the same edge: Instr <= ReadData_i and OldPC <= PC (the pre-update PC, even if PCWrite_i=1 in the same cycle).
- A, B, ALUOut and Data load every cycle, with no enable:
  - A <= RF[rs1], B <= RF[rs2].
  - ALUOut <= ALUResult.
  - Data <= ReadData_i.
- Register file:
  - Read ports are combinational and indexed by Instr[19:15] and Instr[24:20].
  - Write is synchronous: on RegWrite_i=1, RF[Instr[11:7]] <= Result.
  - x0 reads 0 always; writes to x0 are discarded.
  - A read of the register being written in the same cycle returns the old value; there is no bypass.
- Immediate extension (all results sign-extended to 32 bits):
  - I: Instr[31:20].
  - S: {Instr[31:25], Instr[11:7]}.
  - B: {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
  - J: {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
  - U: {Instr[31:12], 12'b0}.
- ALU is combinational on SrcA/SrcB.
  - add and sub wrap modulo 2^32.
  - slt is a signed compare and produces 1 or 0.
  - zero_o is derived from ALUResult in the same cycle.
- Result is a combinational mux per ResultSrc_i. Adr_o = AdrSrc_i ? Result : PC.
- Latency: an instruction is visible on op_o one edge after IRWrite_i. A/B are valid one edge after Instr changes.
- Control-to-action is same-cycle: controls are already registered by the controller, and the datapath adds no extra stage.

Test Plan:
- Reset with RESET_PC=32'h100, hold reset 2 cycles -> PC=0x100, Adr_o=0x100 (AdrSrc_i=0), op_o=0, WriteData_o=0.
- Fetch: ReadData_i=0x00500093 (addi x1,x0,5), IRWrite_i=1, ALUSrcA_i=00, ALUSrcB_i=10, ResultSrc_i=10, PCWrite_i=1, ALUControl_i=000 -> next cycle Instr=0x00500093, OldPC=0x100, PC=0x104, op_o=7'h13.
- ExecuteI then ALUWB with ALUSrcA_i=10, ALUSrcB_i=01, then ResultSrc_i=00, RegWrite_i=1 -> RF[1]=5.
  - Follow with addi x0,x0,7 through the same sequence -> x0 still reads 0.
- beq x1,x1,-8 at PC 0x104: Decode (ALUSrcA_i=01, ALUSrcB_i=01, ImmSrc_i=010) then BEQ (ALUSrcA_i=10, ALUSrcB_i=00, ALUControl_i=001) -> zero_o=1, ALUOut=0xFC. With PCWrite_i=1 and ResultSrc_i=00 -> PC=0xFC.
- lw: ALUOut=0x200, AdrSrc_i=1, ResultSrc_i=00 -> Adr_o=0x200. Next cycle ReadData_i=0xDEADBEEF, then ResultSrc_i=01, RegWrite_i=1 -> rd=0xDEADBEEF. sw of B=0x1234 -> WriteData_o=0x1234.
- slt with A=0xFFFFFFFF, B=1, ALUControl_i=101 -> ALUResult=1, zero_o=0.
  - lui 0x12345 with ImmSrc_i=100, ResultSrc_i=11, RegWrite_i=1 -> rd=0x12345000.
  - Assert reset mid-instruction -> PC=RESET_PC on the next edge and all internal registers clear to 0.

Source files
------------

// File: rtl/mc_datapath_if.sv
// Bundle of control, memory and feedback signals between the multicycle
// controller/memory side and the mc_datapath block.
//   master : controller/memory side; drives controls and ReadData_i,
//            observes address, write data and decode feedback.
//   slave  : datapath side.
interface mc_datapath_if;
  logic        PCWrite_i;
  logic        AdrSrc_i;
  logic        IRWrite_i;
  logic        RegWrite_i;
  logic [1:0]  ALUSrcA_i;
  logic [1:0]  ALUSrcB_i;
  logic [1:0]  ResultSrc_i;
  logic [2:0]  ALUControl_i;
  logic [2:0]  ImmSrc_i;
  logic [31:0] ReadData_i;
  logic [31:0] Adr_o;
  logic [31:0] WriteData_o;
  logic [6:0]  op_o;
  logic [2:0]  funct3_o;
  logic        funct7_o;
  logic        zero_o;

  modport master (
    output PCWrite_i, AdrSrc_i, IRWrite_i, RegWrite_i, ALUSrcA_i, ALUSrcB_i,
           ResultSrc_i, ALUControl_i, ImmSrc_i, ReadData_i,
    input  Adr_o, WriteData_o, op_o, funct3_o, funct7_o, zero_o
  );

  modport slave (
    input  PCWrite_i, AdrSrc_i, IRWrite_i, RegWrite_i, ALUSrcA_i, ALUSrcB_i,
           ResultSrc_i, ALUControl_i, ImmSrc_i, ReadData_i,
    output Adr_o, WriteData_o, op_o, funct3_o, funct7_o, zero_o
  );
endinterface

// File: rtl/mc_datapath.sv
// 32-bit multicycle RV32I datapath.
// Holds PC, OldPC, IR, the A/B/ALUOut/Data holding registers and the 32x32
// register file; applies the controller's registered controls in the same
// cycle.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset (priority over all enables)
//   bus   : mc_datapath_if.slave - controls in, memory address/write data
//           and op/funct3/funct7/zero feedback out
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  mc_datapath_if.slave  bus
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  logic [31:0] pc, old_pc, instr;
  logic [31:0] a_reg, b_reg, alu_out, data_reg;
  logic [31:0] rf [32];

  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rd1, rd2;
  logic [31:0] imm_ext;
  logic [31:0] src_a, src_b;
  logic [31:0] alu_result;
  logic [31:0] result;
  alu_op_e     alu_op;
  imm_src_e    imm_src;

  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign rd      = instr[11:7];
  assign alu_op  = alu_op_e'(bus.ALUControl_i);
  assign imm_src = imm_src_e'(bus.ImmSrc_i);

  // x0 is forced to zero on read; no write-to-read bypass
  assign rd1 = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rd2 = (rs2 == 5'd0) ? '0 : rf[rs2];

  always_comb begin
    imm_ext = {{20{instr[31]}}, instr[31:20]};
    case (imm_src)
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      IMM_U:   imm_ext = {instr[31:12], 12'b0};
      default: imm_ext = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  always_comb begin
    src_a = '0;
    case (bus.ALUSrcA_i)
      2'b00:   src_a = pc;
      2'b01:   src_a = old_pc;
      2'b10:   src_a = a_reg;
      default: src_a = '0;
    endcase
  end

  always_comb begin
    src_b = '0;
    case (bus.ALUSrcB_i)
      2'b00:   src_b = b_reg;
      2'b01:   src_b = imm_ext;
      2'b10:   src_b = 32'd4;
      default: src_b = '0;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (bus.ResultSrc_i)
      2'b00:   result = alu_out;
      2'b01:   result = data_reg;
      2'b10:   result = alu_result;
      default: result = imm_ext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      old_pc   <= '0;
      instr    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      alu_out  <= '0;
      data_reg <= '0;
    end else begin
      if (bus.PCWrite_i) pc <= result;
      // old_pc takes the pre-update pc even when pc is written this edge
      if (bus.IRWrite_i) begin
        instr  <= bus.ReadData_i;
        old_pc <= pc;
      end
      a_reg    <= rd1;
      b_reg    <= rd2;
      alu_out  <= alu_result;
      data_reg <= bus.ReadData_i;
    end
  end

  // Register file contents survive reset; only the write is blocked
  always_ff @(posedge clk) begin
    if (!reset && bus.RegWrite_i && (rd != 5'd0)) rf[rd] <= result;
  end

  assign bus.Adr_o       = bus.AdrSrc_i ? result : pc;
  assign bus.WriteData_o = b_reg;
  assign bus.op_o        = instr[6:0];
  assign bus.funct3_o    = instr[14:12];
  assign bus.funct7_o    = instr[30];
  assign bus.zero_o      = (alu_result == '0);

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;

  typedef enum int {S_ADR, S_WD, S_OP, S_F3, S_F7, S_ZERO} sel_e;

  typedef struct {
    int          cyc;
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  mc_datapath_if bus ();

  mc_datapath #(.RESET_PC(32'h100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.sel)
          S_ADR:   act = bus.Adr_o;
          S_WD:    act = bus.WriteData_o;
          S_OP:    act = {25'b0, bus.op_o};
          S_F3:    act = {29'b0, bus.funct3_o};
          S_F7:    act = {31'b0, bus.funct7_o};
          default: act = {31'b0, bus.zero_o};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s (cycle %0d): got %h expected %h", e.name, e.cyc, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input string name, input sel_e sel, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc; e.name = name; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic idle();
    bus.PCWrite_i    = 1'b0;
    bus.AdrSrc_i     = 1'b0;
    bus.IRWrite_i    = 1'b0;
    bus.RegWrite_i   = 1'b0;
    bus.ALUSrcA_i    = 2'b00;
    bus.ALUSrcB_i    = 2'b00;
    bus.ResultSrc_i  = 2'b00;
    bus.ALUControl_i = 3'b000;
    bus.ImmSrc_i     = 3'b000;
    bus.ReadData_i   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic fetch(input logic [31:0] word, input logic pcw);
    bus.ReadData_i  = word;
    bus.IRWrite_i   = 1'b1;
    bus.PCWrite_i   = pcw;
    bus.ALUSrcB_i   = 2'b10;
    bus.ResultSrc_i = 2'b10;
  endtask

  task automatic show_alu(input logic [1:0] sa, input logic [1:0] sb_sel,
                          input logic [2:0] alu, input logic [2:0] imm);
    bus.ALUSrcA_i    = sa;
    bus.ALUSrcB_i    = sb_sel;
    bus.ALUControl_i = alu;
    bus.ImmSrc_i     = imm;
    bus.ResultSrc_i  = 2'b10;
    bus.AdrSrc_i     = 1'b1;
  endtask

  logic [2:0]  alu_ops [7] = '{3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
  logic [31:0] alu_exp [7] = '{32'h1, 32'h0, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0};

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.Adr_o !== 32'h100) begin
      errors++;
      $display("FAIL rst_adr_direct: got %h expected %h", bus.Adr_o, 32'h100);
    end
    checks++;
    if (bus.op_o !== 7'h0) begin
      errors++;
      $display("FAIL rst_op_direct: got %h expected %h", bus.op_o, 7'h0);
    end
    checks++;
    if (bus.WriteData_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_wd_direct: got %h expected %h", bus.WriteData_o, 32'h0);
    end
    checks++;
    if (bus.funct3_o !== 3'h0) begin
      errors++;
      $display("FAIL rst_f3_direct: got %h expected %h", bus.funct3_o, 3'h0);
    end
    expect_val("rst_adr", S_ADR, 32'h100);
    expect_val("rst_op", S_OP, 32'h0);
    expect_val("rst_wd", S_WD, 32'h0);
    expect_val("rst_f3", S_F3, 32'h0);
    expect_val("rst_f7", S_F7, 32'h0);

    tick(); fetch(32'h0050_0093, 1'b1);
    expect_val("fetch_adr", S_ADR, 32'h100);
    expect_val("fetch_zero", S_ZERO, 32'h0);
    tick(); show_alu(2'b01, 2'b11, 3'b000, 3'b000);
    expect_val("oldpc_prefetch", S_ADR, 32'h100);
    expect_val("addi_op", S_OP, 32'h13);
    tick(); show_alu(2'b10, 2'b01, 3'b000, 3'b000);
    expect_val("addi_exec", S_ADR, 32'h5);
    tick(); bus.ResultSrc_i = 2'b00; bus.RegWrite_i = 1'b1; bus.AdrSrc_i = 1'b1;
    expect_val("addi_aluout", S_ADR, 32'h5);

    tick(); fetch(32'h0070_0013, 1'b0);
    expect_val("pc_hold", S_ADR, 32'h104);
    tick();
    tick(); show_alu(2'b10, 2'b01, 3'b000, 3'b000);
    expect_val("x0_exec", S_ADR, 32'h7);
    tick(); bus.ResultSrc_i = 2'b00; bus.RegWrite_i = 1'b1;
    tick();
    tick(); show_alu(2'b10, 2'b11, 3'b000, 3'b000);
    expect_val("x0_read", S_ADR, 32'h0);

    tick(); fetch(32'hFE10_8CE3, 1'b1);
    expect_val("beq_fetch_adr", S_ADR, 32'h104);
    tick(); show_alu(2'b01, 2'b01, 3'b000, 3'b010);
    expect_val("beq_target", S_ADR, 32'hFC);
    expect_val("beq_op", S_OP, 32'h63);
    tick();
    bus.ALUSrcA_i = 2'b10; bus.ALUSrcB_i = 2'b00; bus.ALUControl_i = 3'b001;
    bus.ResultSrc_i = 2'b00; bus.PCWrite_i = 1'b1;
    expect_val("beq_zero", S_ZERO, 32'h1);
    expect_val("beq_b_x1", S_WD, 32'h5);
    expect_val("beq_pc", S_ADR, 32'h108);

    tick(); fetch(32'h2000_2183, 1'b1);
    expect_val("branch_taken_pc", S_ADR, 32'hFC);
    tick();
    expect_val("lw_op", S_OP, 32'h03);
    expect_val("lw_f3", S_F3, 32'h2);
    tick(); show_alu(2'b10, 2'b01, 3'b000, 3'b000);
    expect_val("lw_memadr", S_ADR, 32'h200);
    tick(); bus.AdrSrc_i = 1'b1; bus.ResultSrc_i = 2'b00; bus.ReadData_i = 32'hDEAD_BEEF;
    expect_val("lw_adr", S_ADR, 32'h200);
    tick(); bus.AdrSrc_i = 1'b1; bus.ResultSrc_i = 2'b01; bus.RegWrite_i = 1'b1;
    expect_val("lw_data", S_ADR, 32'hDEAD_BEEF);

    tick(); fetch(32'h1234_52B7, 1'b0);
    tick(); bus.ImmSrc_i = 3'b100; bus.ResultSrc_i = 2'b11; bus.RegWrite_i = 1'b1; bus.AdrSrc_i = 1'b1;
    expect_val("lui_imm", S_ADR, 32'h1234_5000);
    expect_val("lui_op", S_OP, 32'h37);

    tick(); fetch(32'h0032_A223, 1'b0);
    tick();
    tick(); show_alu(2'b10, 2'b01, 3'b000, 3'b001);
    expect_val("sw_adr", S_ADR, 32'h1234_5004);
    expect_val("sw_wdata", S_WD, 32'hDEAD_BEEF);
    expect_val("sw_op", S_OP, 32'h23);

    tick(); fetch(32'hFFF0_0313, 1'b0);
    tick(); bus.ImmSrc_i = 3'b000; bus.ResultSrc_i = 2'b11; bus.RegWrite_i = 1'b1; bus.AdrSrc_i = 1'b1;
    expect_val("imm_i_neg", S_ADR, 32'hFFFF_FFFF);
    expect_val("funct7_set", S_F7, 32'h1);
    tick(); fetch(32'h0010_0113, 1'b0);
    tick(); bus.ResultSrc_i = 2'b11; bus.RegWrite_i = 1'b1;

    tick(); fetch(32'h0023_23B3, 1'b0);
    tick();
    expect_val("slt_op", S_OP, 32'h33);
    for (int i = 0; i < 7; i++) begin
      tick(); show_alu(2'b10, 2'b00, alu_ops[i], 3'b000);
      expect_val($sformatf("alu_op%0d", i), S_ADR, alu_exp[i]);
      expect_val($sformatf("alu_zero%0d", i), S_ZERO, {31'b0, alu_exp[i] == 32'h0});
    end

    tick(); show_alu(2'b11, 2'b01, 3'b000, 3'b011);
    expect_val("imm_j", S_ADR, 32'h0003_2002);
    tick(); bus.ImmSrc_i = 3'b010; bus.ResultSrc_i = 2'b11; bus.AdrSrc_i = 1'b1;
    expect_val("imm_b", S_ADR, 32'h806);
    tick(); bus.ImmSrc_i = 3'b001; bus.ResultSrc_i = 2'b11; bus.AdrSrc_i = 1'b1;
    expect_val("imm_s", S_ADR, 32'h7);
    tick(); bus.ImmSrc_i = 3'b111; bus.ResultSrc_i = 2'b11; bus.AdrSrc_i = 1'b1;
    expect_val("imm_default_i", S_ADR, 32'h2);

    tick(); reset = 1'b1; fetch(32'hFFFF_FFFF, 1'b1); bus.RegWrite_i = 1'b1;
    tick();
    #1;
    checks++;
    if (bus.Adr_o !== 32'h100) begin
      errors++;
      $display("FAIL mrst_pc_direct: got %h expected %h", bus.Adr_o, 32'h100);
    end
    checks++;
    if (bus.op_o !== 7'h0) begin
      errors++;
      $display("FAIL mrst_op_direct: got %h expected %h", bus.op_o, 7'h0);
    end
    expect_val("mrst_pc", S_ADR, 32'h100);
    expect_val("mrst_op", S_OP, 32'h0);
    expect_val("mrst_wd", S_WD, 32'h0);
    expect_val("mrst_f3", S_F3, 32'h0);
    tick(); bus.AdrSrc_i = 1'b1; bus.ResultSrc_i = 2'b00;
    expect_val("mrst_aluout", S_ADR, 32'h0);
    tick(); bus.AdrSrc_i = 1'b1; bus.ResultSrc_i = 2'b01;
    expect_val("mrst_data", S_ADR, 32'h0);
    tick(); show_alu(2'b10, 2'b11, 3'b000, 3'b000);
    expect_val("mrst_a", S_ADR, 32'h0);
    expect_val("mrst_zero", S_ZERO, 32'h1);
    tick(); show_alu(2'b01, 2'b11, 3'b000, 3'b000);
    expect_val("mrst_oldpc", S_ADR, 32'h0);
    tick(); reset = 1'b0;

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no-sample expected %h", e.name, e.exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
